cordic_req_master: RTL and testbench
====================================

// Module: cordic_req_master
// PURPOSE
//  Drives the CORDIC core's request side (x, y, z, mode, valid_in) and collects its responses (cos, sin, tan_in, valid_out).
//  Upstream pushes commands through a valid/ready port. The block issues each command to the pipelined core one cycle later.
//  It tags each result with its mode and buffers results in a result FIFO. Credit-based issue guarantees the FIFO never overflows.
// PARAMETERS
//  WIDTH      32  operand/result width, signed two's complement
//  RES_DEPTH  16  result FIFO depth = max in-flight + buffered transactions (power of 2)
//  TIMEOUT    64  max cycles allowed between responses while anything is in flight
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  cmd_valid     in   1      command available
//  cmd_ready     out  1      command accepted when cmd_valid & cmd_ready
//  cmd_x/y/z     in   WIDTH  operands
//  cmd_mode      in   1      CORDIC mode (0 rotation, 1 vectoring)
//  c_x/c_y/c_z   out  WIDTH  operands to core, registered
//  c_mode        out  1      mode to core, registered
//  c_valid_in    out  1      one-cycle issue strobe to core
//  c_cos/c_sin   in   WIDTH  core results
//  c_tan_in      in   WIDTH  core third result
//  c_valid_out   in   1      core result strobe
//  res_valid     out  1      result FIFO non-empty (show-ahead)
//  res_ready     in   1      consumer pops when res_valid & res_ready
//  res_cos/res_sin/res_tan  out  WIDTH  head-of-FIFO result
//  res_mode      out  1      mode of the head result
//  inflight      out  $clog2(RES_DEPTH)+1  issued, not yet returned
//  err_clr       in   1      clears sticky errors
//  err_unexp     out  1      sticky: c_valid_out seen while inflight==0
//  err_timeout   out  1      sticky: watchdog expired
// BEHAVIOUR
//  Reset: c_* = 0, c_valid_in = 0, inflight = 0, FIFOs empty, res_valid = 0, res_* = 0, errors = 0, watchdog = 0.
//   Reset mid-operation discards all in-flight and buffered data. Later core strobes then flag err_unexp.
//  Credit: occ = inflight + res_count. cmd_ready = (occ < RES_DEPTH) & ~err_timeout (combinational).
//  Issue: on accept at cycle N, c_x/y/z/mode load at the N edge. c_valid_in = 1 during N+1 only.
//   Back-to-back accepts give c_valid_in high on consecutive cycles. Operands are held when idle.
//  Mode tag: cmd_mode is pushed into the tag FIFO (depth RES_DEPTH) on accept. It pops on each c_valid_out.
//  inflight: +1 on accept, -1 on c_valid_out with inflight > 0. Both in the same cycle leaves it unchanged.
//  Response: when c_valid_out & inflight > 0, {c_cos, c_sin, c_tan_in, tag} is written to the result FIFO that cycle.
//   The entry is visible at res_* the next cycle.
//  Unexpected response: c_valid_out with inflight == 0 writes nothing and sets err_unexp.
//  Result FIFO: simultaneous push and pop is legal at any occupancy, including full and empty.
//   A pop of the last entry with a simultaneous push keeps res_valid = 1.
//   Pointers wrap modulo RES_DEPTH. Credit rules exclude overflow.
//  Watchdog: counts while inflight > 0 and clears on c_valid_out or when inflight == 0.
//   Reaching TIMEOUT sets err_timeout, which blocks new issue (cmd_ready = 0).
//   Already-returned results still drain.
//  err_clr: clears both sticky flags and the watchdog. A same-cycle set event wins over err_clr.
//  Results are assumed to return in order; the core is a fixed-latency pipeline.
// TESTING
//  1 Single cmd x=0x26DD3B6A, y=0, z=0x20000000, mode=0 -> c_valid_in pulses 1 cycle after accept.
//    Core echo 13 cycles later -> res_valid with res_mode=0, inflight back to 0.
//  2 20 back-to-back cmds, res_ready=0 -> exactly 16 accepted.
//    cmd_ready=0 once occ=16; no FIFO overflow; draining 1 result reopens exactly 1 credit.
//  3 Alternating mode 0/1 cmds, random res_ready -> res_mode sequence matches issue order.
//    Results arrive in order with no loss or duplication.
//  4 c_valid_out pulse with inflight=0 -> err_unexp=1, FIFO unchanged; err_clr -> 0 next cycle.
//  5 Issue 1 cmd, suppress core response 64 cycles -> err_timeout=1, cmd_ready=0; err_clr restores issue.
//  6 Assert rst with 5 in flight and 3 buffered -> all outputs 0 immediately.
//    Late core strobes after release set err_unexp.

Source files
------------

// File: rtl/cordic_req_master.sv
// cordic_req_master: issues commands to a pipelined CORDIC core and buffers
// its mode-tagged results in a credit-protected show-ahead FIFO.
`timescale 1ns/1ps

module cordic_req_master #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RES_DEPTH = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    // upstream command port
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [WIDTH-1:0]               cmd_x,
    input  logic [WIDTH-1:0]               cmd_y,
    input  logic [WIDTH-1:0]               cmd_z,
    input  logic                           cmd_mode,
    // core request side
    output logic [WIDTH-1:0]               c_x,
    output logic [WIDTH-1:0]               c_y,
    output logic [WIDTH-1:0]               c_z,
    output logic                           c_mode,
    output logic                           c_valid_in,
    // core response side
    input  logic [WIDTH-1:0]               c_cos,
    input  logic [WIDTH-1:0]               c_sin,
    input  logic [WIDTH-1:0]               c_tan_in,
    input  logic                           c_valid_out,
    // result port
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [WIDTH-1:0]               res_cos,
    output logic [WIDTH-1:0]               res_sin,
    output logic [WIDTH-1:0]               res_tan,
    output logic                           res_mode,
    // status
    output logic [$clog2(RES_DEPTH):0]     inflight,
    input  logic                           err_clr,
    output logic                           err_unexp,
    output logic                           err_timeout
);

    localparam int unsigned AW = $clog2(RES_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = CW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = 3 * WIDTH + 1;

    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_res_count;
    logic [CW-1:0] w_res_cnt_nxt;
    logic [OW-1:0] w_occ;
    logic          w_accept;
    logic          w_have_inflight;
    logic          w_resp;
    logic          w_unexp;
    logic          w_pop;

    logic          r_tag_mem [RES_DEPTH];
    logic [AW-1:0] r_tag_wr;
    logic [AW-1:0] r_tag_rd;

    logic [RW-1:0] r_res_mem [RES_DEPTH];
    logic [AW-1:0] r_res_wr;
    logic [AW-1:0] r_res_rd;
    logic [AW-1:0] w_res_rd_nxt;
    logic [RW-1:0] w_res_wdata;
    logic [RW-1:0] w_head_nxt;
    logic [RW-1:0] r_head;
    logic          r_res_valid;

    logic [TW-1:0] r_wdog;
    logic [TW-1:0] w_wdog_nxt;
    logic          w_to_set;
    logic          r_err_unexp;
    logic          r_err_timeout;

    // Credit: every issued or buffered transaction owns one result FIFO slot
    assign w_occ           = OW'(r_inflight) + OW'(r_res_count);
    assign cmd_ready       = (w_occ < OW'(RES_DEPTH)) & ~r_err_timeout;
    assign w_accept        = cmd_valid & cmd_ready;
    assign w_have_inflight = (r_inflight != '0);
    assign w_resp          = c_valid_out & w_have_inflight;
    assign w_unexp         = c_valid_out & ~w_have_inflight;
    assign w_pop           = r_res_valid & res_ready;

    // Issue register: operands load on accept and hold otherwise; strobe lasts one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_x        <= '0;
            c_y        <= '0;
            c_z        <= '0;
            c_mode     <= 1'b0;
            c_valid_in <= 1'b0;
        end else begin
            c_valid_in <= w_accept;
            if (w_accept) begin
                c_x    <= cmd_x;
                c_y    <= cmd_y;
                c_z    <= cmd_z;
                c_mode <= cmd_mode;
            end
        end
    end

    // In-flight counter: simultaneous issue and return cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else if (w_accept && !w_resp) begin
            r_inflight <= r_inflight + CW'(1);
        end else if (!w_accept && w_resp) begin
            r_inflight <= r_inflight - CW'(1);
        end
    end

    // Mode tag FIFO pointers; occupancy always equals the in-flight count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_accept) r_tag_wr <= r_tag_wr + AW'(1);
            if (w_resp)   r_tag_rd <= r_tag_rd + AW'(1);
        end
    end

    // Mode tag storage
    always_ff @(posedge clk) begin
        if (w_accept) r_tag_mem[r_tag_wr] <= cmd_mode;
    end

    assign w_res_wdata  = {c_cos, c_sin, c_tan_in, r_tag_mem[r_tag_rd]};
    assign w_res_rd_nxt = r_res_rd + AW'(w_pop);

    // Next result count; push and pop together leave it unchanged
    always_comb begin
        w_res_cnt_nxt = r_res_count;
        if (w_resp && !w_pop) begin
            w_res_cnt_nxt = r_res_count + CW'(1);
        end else if (!w_resp && w_pop) begin
            w_res_cnt_nxt = r_res_count - CW'(1);
        end
    end

    // Next head: bypass the write data when it lands in the slot becoming the head
    always_comb begin
        w_head_nxt = r_res_mem[w_res_rd_nxt];
        if (w_resp && (r_res_wr == w_res_rd_nxt)) begin
            w_head_nxt = w_res_wdata;
        end
    end

    // Result FIFO pointers, count and registered show-ahead head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_wr    <= '0;
            r_res_rd    <= '0;
            r_res_count <= '0;
            r_res_valid <= 1'b0;
            r_head      <= '0;
        end else begin
            if (w_resp) r_res_wr <= r_res_wr + AW'(1);
            r_res_rd    <= w_res_rd_nxt;
            r_res_count <= w_res_cnt_nxt;
            r_res_valid <= (w_res_cnt_nxt != '0);
            r_head      <= (w_res_cnt_nxt != '0) ? w_head_nxt : '0;
        end
    end

    // Result storage
    always_ff @(posedge clk) begin
        if (w_resp) r_res_mem[r_res_wr] <= w_res_wdata;
    end

    // Watchdog: counts idle-response cycles while work is outstanding, saturates at expiry
    always_comb begin
        w_wdog_nxt = r_wdog;
        w_to_set   = 1'b0;
        if (c_valid_out || !w_have_inflight) begin
            w_wdog_nxt = '0;
        end else if (r_wdog == TW'(TIMEOUT - 1)) begin
            w_wdog_nxt = TW'(TIMEOUT);
            w_to_set   = 1'b1;
        end else if (err_clr) begin
            w_wdog_nxt = '0;
        end else if (r_wdog != TW'(TIMEOUT)) begin
            w_wdog_nxt = r_wdog + TW'(1);
        end
    end

    // Watchdog register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_nxt;
        end
    end

    // Sticky error flags; a same-cycle set beats err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_unexp   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_unexp)      r_err_unexp <= 1'b1;
            else if (err_clr) r_err_unexp <= 1'b0;
            if (w_to_set)     r_err_timeout <= 1'b1;
            else if (err_clr) r_err_timeout <= 1'b0;
        end
    end

    assign res_valid   = r_res_valid;
    assign res_cos     = r_head[3*WIDTH -: WIDTH];
    assign res_sin     = r_head[2*WIDTH -: WIDTH];
    assign res_tan     = r_head[WIDTH -: WIDTH];
    assign res_mode    = r_head[0];
    assign inflight    = r_inflight;
    assign err_unexp   = r_err_unexp;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_cordic_req_master.sv
// tb_cordic_req_master: scoreboard bench with a fixed-latency echo core model.
`timescale 1ns/1ps

module tb_cordic_req_master;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int          LAT   = 13;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
        logic             m;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_x, cmd_y, cmd_z;
    logic             cmd_mode;
    logic [WIDTH-1:0] c_x, c_y, c_z;
    logic             c_mode;
    logic             c_valid_in;
    logic [WIDTH-1:0] c_cos, c_sin, c_tan_in;
    logic             c_valid_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_cos, res_sin, res_tan;
    logic             res_mode;
    logic [4:0]       inflight;
    logic             err_clr;
    logic             err_unexp;
    logic             err_timeout;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    // consumer policy: 0 hold, 1 always, 2 random, 3 pop pop_budget entries
    int rr_mode    = 0;
    int pop_budget = 0;

    // core model controls
    logic             core_en;
    logic             man_valid;
    logic [WIDTH-1:0] man_x, man_y, man_z;
    logic             pv [LAT];
    logic [WIDTH-1:0] px [LAT];
    logic [WIDTH-1:0] py [LAT];
    logic [WIDTH-1:0] pz [LAT];

    cordic_req_master #(.WIDTH(WIDTH), .RES_DEPTH(DEPTH), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_mode(cmd_mode),
        .c_x(c_x), .c_y(c_y), .c_z(c_z), .c_mode(c_mode), .c_valid_in(c_valid_in),
        .c_cos(c_cos), .c_sin(c_sin), .c_tan_in(c_tan_in), .c_valid_out(c_valid_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_cos(res_cos), .res_sin(res_sin), .res_tan(res_tan), .res_mode(res_mode),
        .inflight(inflight), .err_clr(err_clr),
        .err_unexp(err_unexp), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Echo core: returns {x,y,z} LAT cycles after c_valid_in; not reset with the DUT
    always @(posedge clk) begin
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            px[i] = px[i-1];
            py[i] = py[i-1];
            pz[i] = pz[i-1];
        end
        pv[0] = c_valid_in & core_en;
        px[0] = c_x;
        py[0] = c_y;
        pz[0] = c_z;
        c_valid_out = pv[LAT-1] | man_valid;
        c_cos       = man_valid ? man_x : px[LAT-1];
        c_sin       = man_valid ? man_y : py[LAT-1];
        c_tan_in    = man_valid ? man_z : pz[LAT-1];
    end

    // Consumer and scoreboard compare on every pop
    always @(negedge clk) begin
        case (rr_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            2:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = (pop_budget > 0);
        endcase
        #1;
        if (!rst && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got result cos=%h mode=%0d, required none", res_cos, res_mode);
            end else begin
                mon_e = exp_q.pop_front();
                if (res_cos !== mon_e.x || res_sin !== mon_e.y || res_tan !== mon_e.z || res_mode !== mon_e.m) begin
                    errors++;
                    $display("FAIL scoreboard_result: got %h/%h/%h/%0d, required %h/%h/%h/%0d",
                             res_cos, res_sin, res_tan, res_mode, mon_e.x, mon_e.y, mon_e.z, mon_e.m);
                end
            end
            pops++;
            if (pop_budget > 0) pop_budget--;
        end
    end

    // Offer one command this cycle; call at a negedge, returns at the next negedge
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [WIDTH-1:0] z, input logic m, output bit acc);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_x = x; cmd_y = y; cmd_z = z; cmd_mode = m;
        #1;
        acc = cmd_ready;
        if (acc) begin
            e.x = x; e.y = y; e.z = z; e.m = m;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Bounded wait for everything issued to be returned and consumed
    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || inflight != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || inflight != 0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d inflight=%0d, required 0/0", name, exp_q.size(), inflight);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || c_valid_in !== 1'b0 || c_x !== '0 || res_valid !== 1'b0 ||
            inflight !== 5'd0 || err_unexp !== 1'b0 || err_timeout !== 1'b0 || res_cos !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%0d vin=%0d cx=%h rv=%0d infl=%0d eu=%0d et=%0d, required 1/0/0/0/0/0/0",
                     cmd_ready, c_valid_in, c_x, res_valid, inflight, err_unexp, err_timeout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit acc;
        int p0 = pops;
        rr_mode = 1;
        send(32'h26DD3B6A, 32'h0, 32'h20000000, 1'b0, acc);
        cmd_valid = 1'b0;
        checks++;
        if (acc !== 1'b1 || c_valid_in !== 1'b1 || c_x !== 32'h26DD3B6A || c_z !== 32'h20000000 || inflight !== 5'd1) begin
            errors++;
            $display("FAIL single_issue: acc=%0d vin=%0d cx=%h cz=%h infl=%0d, required 1/1/26dd3b6a/20000000/1",
                     acc, c_valid_in, c_x, c_z, inflight);
        end
        @(negedge clk);
        checks++;
        if (c_valid_in !== 1'b0 || c_x !== 32'h26DD3B6A) begin
            errors++;
            $display("FAIL single_strobe_len: vin=%0d cx=%h, required 0/26dd3b6a", c_valid_in, c_x);
        end
        wait_drain(40, "single");
        checks++;
        if (pops - p0 != 1) begin
            errors++;
            $display("FAIL single_count: popped %0d, required 1", pops - p0);
        end
    endtask

    task automatic test_credit();
        bit acc;
        int cnt = 0;
        int n   = 0;
        int p0;
        rr_mode = 0;
        for (int i = 0; i < 20; i++) begin
            send(32'h1000 + cnt, 32'h2000 + cnt, 32'h3000 + cnt, 1'(cnt), acc);
            if (acc) cnt++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (cnt != 16) begin
            errors++;
            $display("FAIL credit_accepts: got %0d, required 16", cnt);
        end
        while (inflight != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || inflight !== 5'd0) begin
            errors++;
            $display("FAIL credit_full: rdy=%0d rv=%0d infl=%0d, required 0/1/0", cmd_ready, res_valid, inflight);
        end
        p0 = pops;
        pop_budget = 1;
        rr_mode = 3;
        repeat (3) @(negedge clk);
        checks++;
        if (pops - p0 != 1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_reopen: pops=%0d rdy=%0d, required 1/1", pops - p0, cmd_ready);
        end
        rr_mode = 0;
        send(32'hABCD, 32'h1, 32'h2, 1'b1, acc);
        cmd_valid = 1'b0;
        checks++;
        if (acc !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL credit_one: acc=%0d rdy_after=%0d, required 1/0", acc, cmd_ready);
        end
        rr_mode = 1;
        wait_drain(80, "credit");
    endtask

    task automatic test_alt_modes();
        bit acc;
        int p0 = pops;
        rr_mode = 2;
        for (int i = 0; i < 24; i++) begin
            acc = 1'b0;
            while (!acc) send(32'hA000_0000 | WIDTH'(i), 32'hB000_0000 | WIDTH'(i),
                              32'hC000_0000 | WIDTH'(i), 1'(i), acc);
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        wait_drain(300, "alt");
        checks++;
        if (pops - p0 != 24) begin
            errors++;
            $display("FAIL alt_count: popped %0d, required 24", pops - p0);
        end
        rr_mode = 1;
    endtask

    task automatic test_unexp();
        man_x = 32'hDEAD; man_y = 32'hBEEF; man_z = 32'hF00D;
        man_valid = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err_unexp !== 1'b1 || res_valid !== 1'b0 || inflight !== 5'd0) begin
            errors++;
            $display("FAIL unexp_flag: eu=%0d rv=%0d infl=%0d, required 1/0/0", err_unexp, res_valid, inflight);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL unexp_clear: eu=%0d, required 0", err_unexp);
        end
    endtask

    task automatic test_timeout();
        bit acc;
        rr_mode = 1;
        core_en = 1'b0;
        send(32'h5555, 32'h6666, 32'h7777, 1'b1, acc);
        cmd_valid = 1'b0;
        repeat (63) @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: et=%0d, required 0", err_timeout);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_set: et=%0d rdy=%0d, required 1/0", err_timeout, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_x = 32'h9; cmd_y = 32'h9; cmd_z = 32'h9; cmd_mode = 1'b0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (inflight !== 5'd1 || c_valid_in !== 1'b0) begin
            errors++;
            $display("FAIL timeout_block: infl=%0d vin=%0d, required 1/0", inflight, c_valid_in);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: et=%0d rdy=%0d, required 0/1", err_timeout, cmd_ready);
        end
        man_x = 32'h5555; man_y = 32'h6666; man_z = 32'h7777;
        man_valid = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        core_en = 1'b1;
        wait_drain(20, "timeout");
    endtask

    task automatic test_reset_midop();
        bit acc;
        int n = 0;
        rr_mode = 0;
        for (int i = 0; i < 3; i++) send(32'h100 + i, 32'h200 + i, 32'h300 + i, 1'b0, acc);
        cmd_valid = 1'b0;
        while (inflight != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) send(32'h400 + i, 32'h500 + i, 32'h600 + i, 1'b1, acc);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inflight !== 5'd5 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL midop_setup: infl=%0d rv=%0d, required 5/1", inflight, res_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (c_valid_in !== 1'b0 || c_x !== '0 || c_mode !== 1'b0 || res_valid !== 1'b0 ||
            res_cos !== '0 || res_mode !== 1'b0 || inflight !== 5'd0) begin
            errors++;
            $display("FAIL midop_reset: vin=%0d cx=%h cm=%0d rv=%0d rcos=%h rm=%0d infl=%0d, required all 0",
                     c_valid_in, c_x, c_mode, res_valid, res_cos, res_mode, inflight);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (err_unexp !== 1'b1 || inflight !== 5'd0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_late: eu=%0d infl=%0d rv=%0d, required 1/0/0", err_unexp, inflight, res_valid);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0; px[i] = '0; py[i] = '0; pz[i] = '0;
        end
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_z = '0; cmd_mode = 1'b0;
        c_valid_out = 1'b0; c_cos = '0; c_sin = '0; c_tan_in = '0;
        res_ready = 1'b0;
        err_clr = 1'b0;
        core_en = 1'b1;
        man_valid = 1'b0; man_x = '0; man_y = '0; man_z = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_credit();
        test_alt_modes();
        test_unexp();
        test_timeout();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
